// File: rtl/kgp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : kgp_pkg
//  Description : Shared KGP code constants, sequencer state type and the
//                per-bit initial code function for the prefix adder.
//  Revision    : 1.0 - initial release
// ============================================================================
package kgp_pkg;

    // Carry status codes; 2'b10 is never produced
    localparam logic [1:0] KILL = 2'b00;
    localparam logic [1:0] PROP = 2'b01;
    localparam logic [1:0] GEN  = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PREFIX = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Initial code for an operand bit pair: {a&b, a|b} maps 00->KILL,
    // 01/10->PROP, 11->GEN without ever forming the illegal code.
    function automatic logic [1:0] kgp_init(input logic a_bit, input logic b_bit);
        return {a_bit & b_bit, a_bit | b_bit};
    endfunction

endpackage
`default_nettype wire

// File: rtl/kgp_combine_cell.sv
`default_nettype none
// ============================================================================
//  Module      : kgp_combine_cell
//  Description : Kogge-Stone prefix combine on KGP codes: a propagating
//                upper group passes the lower status, otherwise the upper
//                group's own kill/generate wins.
//  Revision    : 1.0 - initial release
// ============================================================================
module kgp_combine_cell
    import kgp_pkg::*;
(
    input  logic [1:0] i_hi,
    input  logic [1:0] i_lo,
    output logic [1:0] o_res
);

    // Upper group decides unless it merely propagates
    assign o_res = (i_hi == PROP) ? i_lo : i_hi;

endmodule
`default_nettype wire

// File: rtl/kgp_prefix_adder_seq.sv
`default_nettype none
// ============================================================================
//  Module      : kgp_prefix_adder_seq
//  Description : Time-multiplexed KGP carry-lookahead adder. One row of
//                combine cells is reused for each Kogge-Stone level (span
//                1, 2, 4, ... WIDTH/2), one level per clock, then sum, carry
//                out and signed overflow are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module kgp_prefix_adder_seq
    import kgp_pkg::*;
#(
    parameter int WIDTH = 64
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = $clog2(WIDTH);
    localparam int CNT_W  = (STAGES > 1) ? $clog2(STAGES) : 1;
    // Level mux is sized to the full counter range; unused codes hold
    localparam int N_SEL  = 1 << CNT_W;
    localparam logic [CNT_W-1:0] C_LAST_STAGE = CNT_W'(STAGES - 1);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [CNT_W-1:0]        r_stage;
    logic [WIDTH-1:0][1:0]   r_kgp;
    logic [WIDTH-1:0][1:0]   w_kgp_init;
    logic [WIDTH-1:0][1:0]   w_kgp_nxt;
    logic [WIDTH-1:0]        w_carry;
    logic [WIDTH-1:0]        r_a;
    logic [WIDTH-1:0]        r_b;
    logic                    r_cin;
    logic [WIDTH-1:0]        r_sum;
    logic                    r_cout;
    logic                    r_ovf;
    logic                    w_ready;
    logic                    w_busy;
    logic                    w_done;
    logic                    w_accept;
    logic                    w_last;

    assign w_accept = start & w_ready;
    assign w_last   = (r_state == PREFIX) && (r_stage == C_LAST_STAGE);

    // Initial codes: bit 0 folds cin in as a majority, so it is only KILL/GEN
    for (genvar i = 0; i < WIDTH; i++) begin : g_init
        if (i == 0) begin : g_lsb
            logic w_maj;
            assign w_maj         = (a[0] & b[0]) | (a[0] & cin) | (b[0] & cin);
            assign w_kgp_init[0] = {w_maj, w_maj};
        end else begin : g_upper
            assign w_kgp_init[i] = kgp_init(a[i], b[i]);
        end
    end

    // Single combine row; the lower input is chosen by the current level
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic [1:0] w_cand [N_SEL];
        for (genvar l = 0; l < N_SEL; l++) begin : g_lvl
            if ((l < STAGES) && (i >= (1 << l))) begin : g_shift
                assign w_cand[l] = r_kgp[i - (1 << l)];
            end else begin : g_hold
                // comb(x, x) == x, so feeding itself leaves the bit unchanged
                assign w_cand[l] = r_kgp[i];
            end
        end

        kgp_combine_cell u_cell (
            .i_hi  (r_kgp[i]),
            .i_lo  (w_cand[r_stage]),
            .o_res (w_kgp_nxt[i])
        );

        assign w_carry[i] = w_kgp_nxt[i][1];
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and status outputs
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready = 1'b1;
                if (start) begin
                    w_state_nxt = PREFIX;
                end
            end
            PREFIX: begin
                w_busy = 1'b1;
                if (r_stage == C_LAST_STAGE) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_ready     = 1'b1;
                w_done      = 1'b1;
                w_state_nxt = start ? PREFIX : IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Operand capture, one prefix level per clock, result registration
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_cin   <= 1'b0;
            r_kgp   <= '0;
            r_stage <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_cin   <= cin;
            r_kgp   <= w_kgp_init;
            r_stage <= '0;
        end else if (r_state == PREFIX) begin
            r_kgp   <= w_kgp_nxt;
            r_stage <= r_stage + CNT_W'(1);
            if (w_last) begin
                // After the final level every code is KILL/GEN: bit1 is the carry
                r_sum  <= r_a ^ r_b ^ {w_carry[WIDTH-2:0], r_cin};
                r_cout <= w_carry[WIDTH-1];
                r_ovf  <= w_carry[WIDTH-2] ^ w_carry[WIDTH-1];
            end
        end
    end

    assign ready = w_ready;
    assign busy  = w_busy;
    assign done  = w_done;
    assign sum   = r_sum;
    assign cout  = r_cout;
    assign ovf   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_kgp_prefix_adder_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_kgp_prefix_adder_seq
//  Description : Directed self-checking bench for kgp_prefix_adder_seq at
//                WIDTH=64 with hand-computed expected results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_kgp_prefix_adder_seq;

    localparam int WIDTH   = 64;
    localparam int STAGES  = 6;
    localparam int MAX_WAIT = 20;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int tests = 0;
    int fails = 0;
    logic seen_illegal = 1'b0;

    kgp_prefix_adder_seq #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    // Watch the internal code register for the never-generated 2'b10
    always @(negedge clk) begin
        for (int i = 0; i < WIDTH; i++) begin
            if (dut.r_kgp[i] == 2'b10) seen_illegal = 1'b1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance clock edges until done is seen (sampled 1ns after each edge)
    task automatic wait_done(output int edges, output logic bad_status);
        edges = 0;
        bad_status = 1'b0;
        while (edges < MAX_WAIT) begin
            @(posedge clk);
            #1;
            edges++;
            if (done) break;
            if (!busy || ready) bad_status = 1'b1;
        end
    endtask

    // Accept one operation, scramble inputs while busy, check results
    task automatic run_op(input string tag, input logic [63:0] ta, input logic [63:0] tb_v,
                          input logic tc, input logic [63:0] es, input logic ec, input logic eo);
        int   edges;
        logic bad;
        @(negedge clk);
        a = ta; b = tb_v; cin = tc; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; cin = 1'($urandom);
        wait_done(edges, bad);
        check({tag, "_latency"}, 64'(edges), 64'(STAGES));
        check({tag, "_status"},  64'(bad), 64'd0);
        check({tag, "_sum"},     sum, es);
        check({tag, "_cout_ovf"}, {62'd0, cout, ovf}, {62'd0, ec, eo});
    endtask

    initial begin
        int   edges;
        logic bad;
        logic seen_done;

        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_status", {61'd0, ready, busy, done}, {61'd0, 3'b100});
        check("reset_results", {sum[31:0], 30'd0, cout, ovf}, 64'd0);
        rst = 1'b0;

        run_op("zero",      64'h0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0);
        run_op("prop_chain", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1, 1'b0);
        run_op("pos_ovf",   64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
        run_op("neg_ovf",   64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1'b1);
        run_op("mixed",     64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0,
               64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        run_op("mixed_cin", 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1,
               64'h0, 1'b1, 1'b0);
        run_op("neg_plus",  64'hFFFF_FFFF_FFFF_FFFE, 64'h5, 1'b0, 64'h3, 1'b1, 1'b0);

        // Busy rejection: second start during PREFIX must be ignored
        @(negedge clk);
        a = 64'd5; b = 64'd3; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        a = 64'd100; b = 64'd100; start = 1'b1;
        check("busy_ready_low", {62'd0, ready, busy}, {62'd0, 2'b01});
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(edges, bad);
        check("busy_latency", 64'(edges + 2), 64'(STAGES));
        check("busy_status", 64'(bad), 64'd0);
        check("busy_sum", sum, 64'd8);
        @(posedge clk);
        #1;
        check("busy_single_done", {61'd0, ready, busy, done}, {61'd0, 3'b100});

        // Back-to-back: start held high, second operands presented in DONE
        @(negedge clk);
        a = 64'd1; b = 64'd2; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        wait_done(edges, bad);
        check("b2b_first_latency", 64'(edges), 64'(STAGES));
        check("b2b_first_sum", sum, 64'd3);
        a = 64'd10; b = 64'd20; cin = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_no_idle", {61'd0, ready, busy, done}, {61'd0, 3'b010});
        check("b2b_sum_hold", sum, 64'd3);
        wait_done(edges, bad);
        check("b2b_second_latency", 64'(edges + 1), 64'(STAGES + 1));
        check("b2b_second_sum", sum, 64'd30);

        // Reset mid-PREFIX aborts without a done pulse
        @(negedge clk);
        a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'hFFFF_FFFF_FFFF_FFFF; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_mid_status", {61'd0, ready, busy, done}, {61'd0, 3'b100});
        check("rst_mid_results", {sum[61:0], cout, ovf}, 64'd0);
        seen_done = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (done) seen_done = 1'b1;
        end
        check("rst_no_done", 64'(seen_done), 64'd0);

        run_op("after_rst", 64'd2, 64'd2, 1'b0, 64'd4, 1'b0, 1'b0);

        check("kgp_legal", 64'(seen_illegal), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Absolute time bound in case the sequence stalls
    initial begin
        #200000;
        $display("FAIL timeout: observed no completion, required finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
